// File: rtl/xorshift_stream.sv
// Xorshift PRNG (32- or 64-bit state) driving a ready/valid word stream, with
// runtime seeding, zero-seed protection, warm-up discard and a word counter.
module xorshift_stream #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      WARMUP       = 0,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             seed_err,
   output logic [31:0]      gen_count,
   output logic             fsm_dbg
);

   generate
      if ((WIDTH != 32) && (WIDTH != 64)) begin : g_bad_width
         $error("xorshift_stream: WIDTH must be 32 or 64");
      end
      if (WARMUP > 255) begin : g_bad_warmup
         $error("xorshift_stream: WARMUP must be 0..255");
      end
      if (DEFAULT_SEED == '0) begin : g_bad_seed
         $error("xorshift_stream: DEFAULT_SEED must be nonzero");
      end
   endgenerate

   localparam int SH_A = 13;
   localparam int SH_B = (WIDTH == 64) ? 7 : 17;
   localparam int SH_C = (WIDTH == 64) ? 17 : 5;
   localparam logic [7:0] WARM_INIT = WARMUP[7:0];

   typedef enum logic {WARM = 1'b0, RUN = 1'b1} fsm_t;
   localparam fsm_t FSM_INIT = (WARMUP > 0) ? WARM : RUN;

   // Handshake: a word in out is transferred on any edge where out_valid and
   // out_ready are both high; out and out_valid are held while out_ready is low.

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] t;
      t = v ^ (v << SH_A);
      t = t ^ (t >> SH_B);
      t = t ^ (t << SH_C);
      return t;
   endfunction

   fsm_t             fsm;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] x_step;
   logic [7:0]       warm_cnt;
   logic             slot_free;

   assign x_step    = step(x);
   assign slot_free = !out_valid || out_ready;
   assign fsm_dbg   = (fsm == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= DEFAULT_SEED;
         warm_cnt  <= WARM_INIT;
         fsm       <= FSM_INIT;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= (FSM_INIT == WARM);
         seed_err  <= 1'b0;
         gen_count <= '0;
      end else begin
         seed_err <= 1'b0;
         if (seed_load) begin
            // A zero seed would lock xorshift at zero forever; substitute and flag it.
            x         <= (seed == '0) ? DEFAULT_SEED : seed;
            seed_err  <= (seed == '0);
            warm_cnt  <= WARM_INIT;
            fsm       <= FSM_INIT;
            busy      <= (FSM_INIT == WARM);
            out_valid <= 1'b0;
            gen_count <= '0;
         end else begin
            case (fsm)
               WARM: begin
                  if (en) begin
                     x        <= x_step;
                     warm_cnt <= warm_cnt - 8'd1;
                     if (warm_cnt == 8'd1) begin
                        fsm  <= RUN;
                        busy <= 1'b0;
                     end
                  end
               end
               RUN: begin
                  if (en && slot_free) begin
                     x         <= x_step;
                     out       <= x_step;
                     out_valid <= 1'b1;
                     gen_count <= gen_count + 32'd1;
                  end else if (out_valid && out_ready) begin
                     out_valid <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xorshift_stream.sv
// Directed bench for xorshift_stream: 32-bit instances with WARMUP 0/1/4 and a
// 64-bit instance, all sharing control inputs, checked with immediate assertions.
module tb_xorshift_stream;

   logic        clk;
   logic        rst;
   logic        en;
   logic        seed_load;
   logic        out_ready;
   logic [31:0] seed32;
   logic [63:0] seed64;

   logic [31:0] o0, o1, o4;
   logic [63:0] o64;
   logic        v0, v1, v4, v64;
   logic        b0, b1, b4, b64;
   logic        e0, e1, e4, e64;
   logic [31:0] c0, c1, c4, c64;
   logic        f0, f1, f4, f64;

   int checks;
   int errors;
   logic [63:0] exp_q[$];

   xorshift_stream #(.WIDTH(32), .WARMUP(0)) u0 (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed32),
      .out(o0), .out_valid(v0), .out_ready(out_ready), .busy(b0),
      .seed_err(e0), .gen_count(c0), .fsm_dbg(f0));

   xorshift_stream #(.WIDTH(32), .WARMUP(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed32),
      .out(o1), .out_valid(v1), .out_ready(out_ready), .busy(b1),
      .seed_err(e1), .gen_count(c1), .fsm_dbg(f1));

   xorshift_stream #(.WIDTH(32), .WARMUP(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed32),
      .out(o4), .out_valid(v4), .out_ready(out_ready), .busy(b4),
      .seed_err(e4), .gen_count(c4), .fsm_dbg(f4));

   xorshift_stream #(.WIDTH(64), .WARMUP(0), .DEFAULT_SEED(64'd1)) u64 (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed64),
      .out(o64), .out_valid(v64), .out_ready(out_ready), .busy(b64),
      .seed_err(e64), .gen_count(c64), .fsm_dbg(f64));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] s32(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   function automatic logic [63:0] s64(input logic [63:0] v);
      logic [63:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 7);
      t = t ^ (t << 17);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] m;
      logic [31:0] m4;
      logic [31:0] eo;
      logic        ev;
      int          warm_left;
      logic [63:0] m64;
      logic [39:0] en_pat;

      checks = 0;
      errors = 0;
      rst = 1'b1; en = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
      seed32 = '0; seed64 = '0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      chk("rst_out",   o0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_busy0", b0, 0);
      chk("rst_err",   e0, 0);
      chk("rst_cnt",   c0, 0);
      chk("rst_fsm0",  f0, 1);
      chk("rst_busy1", b1, 1);
      chk("rst_busy4", b4, 1);
      chk("rst_fsm4",  f4, 0);

      // WARMUP=0 first two words straight from reset
      en = 1'b1;
      tick();
      chk("w0_out1", o0, 32'h0004_2021);
      chk("w0_v1",   v0, 1);
      chk("w0_cnt1", c0, 1);
      chk("w0_busy", b0, 0);
      chk("w1_busy_a", b1, 0);
      tick();
      chk("w0_out2", o0, 32'h0408_0601);
      chk("w0_cnt2", c0, 2);
      chk("w0_busy2", b0, 0);

      // WARMUP=1 after seed_load seed=1
      en = 1'b0; seed_load = 1'b1; seed32 = 32'd1;
      tick();
      seed_load = 1'b0;
      chk("w1_busy_load", b1, 1);
      chk("w1_v_load",    v1, 0);
      chk("w1_cnt_load",  c1, 0);
      chk("w1_err_load",  e1, 0);
      en = 1'b1;
      tick();
      chk("w1_busy_run", b1, 0);
      chk("w1_v_warm",   v1, 0);
      tick();
      chk("w1_out1", o1, 32'h0408_0601);
      chk("w1_v1",   v1, 1);
      chk("w1_cnt1", c1, 1);

      // zero seed substitution
      en = 1'b0; seed_load = 1'b1; seed32 = 32'd0;
      tick();
      seed_load = 1'b0;
      chk("z_err",   e0, 1);
      chk("z_valid", v0, 0);
      chk("z_cnt",   c0, 0);
      en = 1'b1;
      tick();
      chk("z_err_clr", e0, 0);
      chk("z_out",     o0, 32'h0004_2021);
      chk("z_cnt1",    c0, 1);

      // backpressure: word held 5 cycles, then stream resumes without gaps
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out",   o0, 32'h0004_2021);
         chk("bp_cnt",   c0, 1);
         chk("bp_valid", v0, 1);
         chk("bp_err",   e0, 0);
      end
      out_ready = 1'b1;
      m = 32'h0004_2021;
      for (int i = 0; i < 4; i++) begin
         tick();
         m = s32(m);
         chk("bp_resume", o0, m);
         chk("bp_rcnt",   c0, 32'(i + 2));
      end

      // seed_load while stalled drops the pending word
      out_ready = 1'b0;
      seed_load = 1'b1; seed32 = 32'h1234_5678;
      tick();
      seed_load = 1'b0;
      chk("bps_valid", v0, 0);
      chk("bps_cnt",   c0, 0);
      chk("bps_err",   e0, 0);
      out_ready = 1'b1;
      tick();
      chk("bps_out", o0, s32(32'h1234_5678));
      chk("bps_v",   v0, 1);
      chk("bps_c",   c0, 1);

      // WARMUP=4 with en toggling: stream must equal the unstalled sequence
      en = 1'b0; seed_load = 1'b1; seed32 = 32'hDEAD_BEEF;
      tick();
      seed_load = 1'b0;
      chk("t_busy_load", b4, 1);
      en_pat = 40'b1101_0110_0111_0010_1101_1100_0101_1011_1001_1110;
      m4 = 32'hDEAD_BEEF;
      warm_left = 4;
      ev = 1'b0;
      eo = '0;
      for (int i = 0; i < 40; i++) begin
         en = en_pat[i];
         tick();
         if (en_pat[i]) begin
            m4 = s32(m4);
            if (warm_left > 0) begin
               warm_left--;
               ev = 1'b0;
            end else begin
               ev = 1'b1;
               eo = m4;
            end
         end else begin
            ev = 1'b0;
         end
         chk("t_busy",  b4, (warm_left > 0));
         chk("t_valid", v4, ev);
         if (ev) chk("t_out", o4, eo);
      end

      // 64-bit stream against a software model
      en = 1'b0; seed_load = 1'b1; seed64 = 64'd1;
      tick();
      seed_load = 1'b0;
      chk("x64_busy", b64, 0);
      m64 = 64'd1;
      for (int i = 0; i < 1000; i++) begin
         m64 = s64(m64);
         exp_q.push_back(m64);
      end
      en = 1'b1;
      tick();
      chk("x64_first", o64, 64'h0000_0000_4082_2041);
      chk("x64_q0", o64, exp_q.pop_front());
      for (int i = 1; i < 1000; i++) begin
         tick();
         chk("x64_q", o64, exp_q.pop_front());
      end
      chk("x64_cnt", c64, 1000);

      // counter wrap
      force u64.gen_count = 32'hFFFF_FFFF;
      #1;
      release u64.gen_count;
      tick();
      chk("wrap_cnt", c64, 0);
      chk("wrap_out", o64, s64(m64));

      // reset mid-stream
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_out",   o0, 0);
      chk("mrst_valid", v0, 0);
      chk("mrst_cnt",   c0, 0);
      chk("mrst_busy4", b4, 1);
      chk("mrst_out64", o64, 0);
      chk("mrst_cnt64", c64, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
